eth_rx_noc_out_mc_ctrl: RTL and testbench
=========================================

// Module: eth_rx_noc_out_mc_ctrl
// PURPOSE
// Control FSM for the Ethernet RX tile NoC output stage, generalised to NUM_DST NoC output channels.
// The CAM lookup returns hit plus a destination channel index.
// Emits one header flit, META_FLITS metadata flits and the payload data flits on that channel only.
// Misses are drained without back-pressure from any NoC channel and are counted.
// PARAMETERS
// NUM_DST     2   number of NoC output channels (>=1)
// DST_W       $clog2(NUM_DST)>0 ? $clog2(NUM_DST) : 1   width of channel index
// META_FLITS  1   metadata flits per packet after header (0..15)
// CNT_W       32  width of packet/drop counters
// PORTS
// clk                        in   1          clock
// rst                        in   1          async reset, active-high
// hdr_val                    in   1          header from eth_format valid
// hdr_rdy                    out  1          header accepted
// data_val                   in   1          payload flit valid
// data_last                  in   1          last payload flit of packet
// data_rdy                   out  1          payload flit accepted
// noc_out_val                out  NUM_DST    per-channel flit valid (one-hot or zero)
// noc_out_rdy                in   NUM_DST    per-channel ready
// cam_rd                     out  1          CAM lookup strobe
// cam_hit                    in   1          CAM hit (combinational, same cycle as cam_rd)
// cam_dst                    in   DST_W      destination channel on hit
// flit_sel                   out  2          eth_rx_tile_pkg::noc_out_flit_mux_sel (HDR/META/DATA)
// meta_idx                   out  4          index of metadata flit being sent
// store_inputs               out  1          datapath latch header/metadata
// incr_packet_num            out  1          pulse on delivered packet completion
// drop_cnt_clr               in   1          synchronous clear of drop_cnt
// drop_cnt                   out  CNT_W      saturating count of dropped packets
// pkt_cnt                    out  CNT_W      wrapping count of delivered packets
// BEHAVIOUR
// - Reset: state=READY, dst_reg=0, meta_cnt=0, drop_cnt=0, pkt_cnt=0.
//   All val/rdy/strobe outputs are 0; flit_sel=HDR.
// - The active channel is dst = (state==READY) ? cam_dst : dst_reg.
//   noc_out_val may assert only bit dst; all other bits are 0.
// - READY:
//   - cam_rd=1, flit_sel=HDR.
//   - If cam_hit: noc_out_val[dst]=hdr_val and hdr_rdy=noc_out_rdy[cam_dst].
//   - If miss: noc_out_val=0 and hdr_rdy=1.
//   - Header handshake: store_inputs=1 and dst_reg<=cam_dst. Next state is:
//     - META if hit and META_FLITS>0;
//     - DATA if hit and META_FLITS==0;
//     - DROP on miss.
// - META:
//   - flit_sel=META, meta_idx=meta_cnt, noc_out_val[dst_reg]=1.
//   - On rdy: if meta_cnt==META_FLITS-1, meta_cnt<=0 and go to DATA; otherwise meta_cnt++.
// - DATA:
//   - flit_sel=DATA, noc_out_val[dst_reg]=data_val, data_rdy=noc_out_rdy[dst_reg].
//   - On val&rdy&data_last: incr_packet_num=1, pkt_cnt++ (wraps), then READY.
// - DROP:
//   - data_rdy=1, noc_out_val=0.
//   - On data_val&data_last: drop_cnt++ (saturates at all-ones), then READY.
// - Latency:
//   - No pipeline registers on the flit path; val/rdy are combinational pass-through.
//   - Packet turnaround is 0 idle cycles: the cycle after the last data flit is READY.
// - No flit may be lost or duplicated under arbitrary noc_out_rdy toggling.
//   Outputs hold stable while val && !rdy.
// - drop_cnt_clr coincident with a drop increment yields drop_cnt=1 (clear, then count).
// - Reset asserted mid-packet aborts immediately and returns to READY.
//   Upstream is responsible for flushing; no partial-packet recovery.
// - Illegal cam_dst>=NUM_DST on hit is treated as a miss (DROP, counted).
// TESTING
// - NUM_DST=4, META_FLITS=2, hit dst=2, 3 data flits, rdy=1 ->
//   ch2 sees HDR,M0,M1,D,D,D in 6 cycles; other channels are silent; pkt_cnt=1.
// - Miss with ch0..3 rdy=0, 5-flit payload -> hdr_rdy=1, all 5 flits drained, no noc_out_val, drop_cnt=1.
// - Hit dst=1, rdy[1] toggling 1-0-1-0 on every flit -> flit order intact, no duplicates, meta_idx 0 then 1.
// - META_FLITS=0, hit dst=3, 1-flit payload (data_last on first) -> HDR then D, back in READY on next cycle.
// - Saturation: preload drop_cnt to 2^CNT_W-2, drop 3 packets -> drop_cnt stays all-ones.
//   drop_cnt_clr coincident with a drop -> drop_cnt=1.
// - rst pulsed during DATA of a hit packet -> all outputs 0 the same cycle; FSM in READY, counters 0.

Source files
------------

// File: rtl/eth_rx_noc_out_mc_ctrl.sv
// Control FSM for the Ethernet RX tile NoC output stage with NUM_DST channels.
// A CAM hit routes one header flit, META_FLITS metadata flits and the payload
// to a single channel. Misses are drained locally and counted. The flit path
// is purely combinational: val/rdy pass straight through with no staging.
module eth_rx_noc_out_mc_ctrl #(
    parameter int NUM_DST    = 2,
    parameter int DST_W      = ($clog2(NUM_DST) > 0) ? $clog2(NUM_DST) : 1,
    parameter int META_FLITS = 1,
    parameter int CNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hdr_val,
    output logic               hdr_rdy,
    input  logic               data_val,
    input  logic               data_last,
    output logic               data_rdy,
    output logic [NUM_DST-1:0] noc_out_val,
    input  logic [NUM_DST-1:0] noc_out_rdy,
    output logic               cam_rd,
    input  logic               cam_hit,
    input  logic [DST_W-1:0]   cam_dst,
    output logic [1:0]         flit_sel,
    output logic [3:0]         meta_idx,
    output logic               store_inputs,
    output logic               incr_packet_num,
    input  logic               drop_cnt_clr,
    output logic [CNT_W-1:0]   drop_cnt,
    output logic [CNT_W-1:0]   pkt_cnt
);

    // Flit mux select encoding shared with the datapath
    localparam logic [1:0] SEL_HDR  = 2'd0;
    localparam logic [1:0] SEL_META = 2'd1;
    localparam logic [1:0] SEL_DATA = 2'd2;

    localparam logic [3:0] META_LAST = (META_FLITS > 0) ? 4'(META_FLITS - 1) : 4'd0;

    typedef enum logic [1:0] {
        READY = 2'd0,
        META  = 2'd1,
        DATA  = 2'd2,
        DROP  = 2'd3
    } state_t;

    state_t           state;
    logic [DST_W-1:0] dst_reg;
    logic [3:0]       meta_cnt;

    logic [DST_W-1:0] dst;
    logic             dst_ok;
    logic             dst_rdy;
    logic             hit_ok;
    logic             flit_val;
    logic             hdr_rdy_i;
    logic             data_rdy_i;
    logic             cam_rd_i;
    logic [1:0]       flit_sel_i;
    logic             store_i;
    logic             incr_i;
    logic             drop_inc;

    assign dst    = (state == READY) ? cam_dst : dst_reg;
    assign dst_ok = (32'(dst) < NUM_DST);
    // An out-of-range channel index on a hit cannot be delivered, so it is a miss
    assign hit_ok = cam_hit && (32'(cam_dst) < NUM_DST);

    // Ready of the currently addressed channel
    always_comb begin
        dst_rdy = 1'b0;
        for (int i = 0; i < NUM_DST; i++) begin
            if (dst == DST_W'(i)) dst_rdy = noc_out_rdy[i];
        end
    end

    // Per-state handshake and mux control decode
    always_comb begin
        flit_val   = 1'b0;
        hdr_rdy_i  = 1'b0;
        data_rdy_i = 1'b0;
        cam_rd_i   = 1'b0;
        flit_sel_i = SEL_HDR;
        store_i    = 1'b0;
        incr_i     = 1'b0;
        drop_inc   = 1'b0;
        case (state)
            READY: begin
                cam_rd_i = 1'b1;
                if (hit_ok) begin
                    flit_val  = hdr_val;
                    hdr_rdy_i = dst_rdy;
                end else begin
                    hdr_rdy_i = 1'b1;
                end
                store_i = hdr_val && hdr_rdy_i;
            end
            META: begin
                flit_sel_i = SEL_META;
                flit_val   = 1'b1;
            end
            DATA: begin
                flit_sel_i = SEL_DATA;
                flit_val   = data_val;
                data_rdy_i = dst_rdy;
                incr_i     = data_val && dst_rdy && data_last;
            end
            default: begin
                flit_sel_i = SEL_DATA;
                data_rdy_i = 1'b1;
                drop_inc   = data_val && data_last;
            end
        endcase
    end

    // Outputs forced quiet while reset is held so an abort is visible at once
    always_comb begin
        for (int i = 0; i < NUM_DST; i++) begin
            noc_out_val[i] = !rst && flit_val && dst_ok && (dst == DST_W'(i));
        end
        hdr_rdy         = !rst && hdr_rdy_i;
        data_rdy        = !rst && data_rdy_i;
        cam_rd          = !rst && cam_rd_i;
        store_inputs    = !rst && store_i;
        incr_packet_num = !rst && incr_i;
        flit_sel        = rst ? SEL_HDR : flit_sel_i;
        meta_idx        = rst ? 4'd0 : meta_cnt;
    end

    // Packet sequencing: header, metadata, payload or drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= READY;
            dst_reg  <= '0;
            meta_cnt <= '0;
        end else begin
            case (state)
                READY: begin
                    if (store_i) begin
                        dst_reg <= cam_dst;
                        if (!hit_ok)             state <= DROP;
                        else if (META_FLITS > 0) state <= META;
                        else                     state <= DATA;
                    end
                end
                META: begin
                    if (dst_rdy) begin
                        if (meta_cnt == META_LAST) begin
                            meta_cnt <= '0;
                            state    <= DATA;
                        end else begin
                            meta_cnt <= meta_cnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (incr_i) state <= READY;
                end
                default: begin
                    if (drop_inc) state <= READY;
                end
            endcase
        end
    end

    // Delivered-packet counter, wraps
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         pkt_cnt <= '0;
        else if (incr_i) pkt_cnt <= pkt_cnt + CNT_W'(1);
    end

    // Dropped-packet counter, saturates; a clear takes effect before a same-cycle drop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop_cnt_clr) begin
            drop_cnt <= drop_inc ? CNT_W'(1) : '0;
        end else if (drop_inc && (drop_cnt != {CNT_W{1'b1}})) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_eth_rx_noc_out_mc_ctrl.sv
// Directed bench: main instance (4 ch, 2 meta), a 3-channel 2-bit-counter
// instance for illegal index and saturation, and a zero-metadata instance.
module tb_eth_rx_noc_out_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       hdr_val, data_val, data_last, cam_hit, clr;
    logic [3:0] rdy;
    logic [1:0] dst;

    // main: NUM_DST=4, META_FLITS=2, CNT_W=32
    logic        m_hdr_rdy, m_data_rdy, m_cam_rd, m_store, m_incr;
    logic [3:0]  m_val, m_meta;
    logic [1:0]  m_sel;
    logic [31:0] m_drop, m_pkt;
    // sat: NUM_DST=3, META_FLITS=2, CNT_W=2
    logic        s_hdr_rdy, s_data_rdy, s_cam_rd, s_store, s_incr;
    logic [2:0]  s_val;
    logic [3:0]  s_meta;
    logic [1:0]  s_sel, s_drop, s_pkt;
    // z: NUM_DST=4, META_FLITS=0, CNT_W=8
    logic        z_hdr_rdy, z_data_rdy, z_cam_rd, z_store, z_incr;
    logic [3:0]  z_val, z_meta;
    logic [1:0]  z_sel;
    logic [7:0]  z_drop, z_pkt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    eth_rx_noc_out_mc_ctrl #(.NUM_DST(4), .META_FLITS(2), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .hdr_val(hdr_val), .hdr_rdy(m_hdr_rdy),
        .data_val(data_val), .data_last(data_last), .data_rdy(m_data_rdy),
        .noc_out_val(m_val), .noc_out_rdy(rdy), .cam_rd(m_cam_rd),
        .cam_hit(cam_hit), .cam_dst(dst), .flit_sel(m_sel), .meta_idx(m_meta),
        .store_inputs(m_store), .incr_packet_num(m_incr),
        .drop_cnt_clr(clr), .drop_cnt(m_drop), .pkt_cnt(m_pkt));

    eth_rx_noc_out_mc_ctrl #(.NUM_DST(3), .META_FLITS(2), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .hdr_val(hdr_val), .hdr_rdy(s_hdr_rdy),
        .data_val(data_val), .data_last(data_last), .data_rdy(s_data_rdy),
        .noc_out_val(s_val), .noc_out_rdy(rdy[2:0]), .cam_rd(s_cam_rd),
        .cam_hit(cam_hit), .cam_dst(dst), .flit_sel(s_sel), .meta_idx(s_meta),
        .store_inputs(s_store), .incr_packet_num(s_incr),
        .drop_cnt_clr(clr), .drop_cnt(s_drop), .pkt_cnt(s_pkt));

    eth_rx_noc_out_mc_ctrl #(.NUM_DST(4), .META_FLITS(0), .CNT_W(8)) u_m0 (
        .clk(clk), .rst(rst), .hdr_val(hdr_val), .hdr_rdy(z_hdr_rdy),
        .data_val(data_val), .data_last(data_last), .data_rdy(z_data_rdy),
        .noc_out_val(z_val), .noc_out_rdy(rdy), .cam_rd(z_cam_rd),
        .cam_hit(cam_hit), .cam_dst(dst), .flit_sel(z_sel), .meta_idx(z_meta),
        .store_inputs(z_store), .incr_packet_num(z_incr),
        .drop_cnt_clr(clr), .drop_cnt(z_drop), .pkt_cnt(z_pkt));

    typedef struct {
        logic        hv, dv, dl;
        logic [3:0]  rdy;
        logic        hit;
        logic [1:0]  dst;
        logic [14:0] exp;  // {cam_rd,hdr_rdy,data_rdy,store,incr,val[3:0],sel,meta_idx}
    } vec_t;

    vec_t vecs[$];

    function automatic logic [14:0] o(logic cr, logic hr, logic dr, logic st, logic inc,
                                      logic [3:0] v, logic [1:0] s, logic [3:0] mi);
        return {cr, hr, dr, st, inc, v, s, mi};
    endfunction

    function automatic logic [14:0] m_act();
        return {m_cam_rd, m_hdr_rdy, m_data_rdy, m_store, m_incr, m_val, m_sel, m_meta};
    endfunction

    task automatic add(logic hv, logic dv, logic dl, logic [3:0] r, logic h, logic [1:0] d,
                       logic [14:0] e);
        vec_t v;
        v.hv = hv; v.dv = dv; v.dl = dl; v.rdy = r; v.hit = h; v.dst = d; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, exp);
        end
    endtask

    task automatic idle();
        hdr_val = 0; data_val = 0; data_last = 0; cam_hit = 0; dst = 0; clr = 0; rdy = 4'hf;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Apply table rows [first, last], one row per cycle, checking the main instance
    task automatic run_rows(int first, int last);
        for (int i = first; i <= last; i++) begin
            hdr_val = vecs[i].hv; data_val = vecs[i].dv; data_last = vecs[i].dl;
            rdy = vecs[i].rdy; cam_hit = vecs[i].hit; dst = vecs[i].dst;
            @(negedge clk);
            chk($sformatf("row%0d", i), 32'(m_act()), 32'(vecs[i].exp));
            @(posedge clk); #1;
        end
        idle();
    endtask

    // One missed packet: header cycle then a single last payload flit
    task automatic drop_pkt(logic c);
        idle(); hdr_val = 1; cam_hit = 0;
        @(posedge clk); #1;
        idle(); data_val = 1; data_last = 1; clr = c;
        @(posedge clk); #1;
        idle();
    endtask

    initial begin
        // scenario A rows 0..6: hit dst=2, rdy all 1, 2 meta, 3 data
        add(1,0,0,4'hf,1,2, o(1,1,0,1,0,4'b0100,2'd0,4'd0));
        add(0,0,0,4'hf,0,0, o(0,0,0,0,0,4'b0100,2'd1,4'd0));
        add(0,0,0,4'hf,0,0, o(0,0,0,0,0,4'b0100,2'd1,4'd1));
        add(0,1,0,4'hf,0,0, o(0,0,1,0,0,4'b0100,2'd2,4'd0));
        add(0,1,0,4'hf,0,0, o(0,0,1,0,0,4'b0100,2'd2,4'd0));
        add(0,1,1,4'hf,0,0, o(0,0,1,0,1,4'b0100,2'd2,4'd0));
        add(0,0,0,4'hf,0,0, o(1,1,0,0,0,4'b0000,2'd0,4'd0));
        // scenario B rows 7..13: miss, all rdy low, 5 flits drained
        add(1,0,0,4'h0,0,0, o(1,1,0,1,0,4'b0000,2'd0,4'd0));
        add(0,1,0,4'h0,0,0, o(0,0,1,0,0,4'b0000,2'd2,4'd0));
        add(0,1,0,4'h0,0,0, o(0,0,1,0,0,4'b0000,2'd2,4'd0));
        add(0,1,0,4'h0,0,0, o(0,0,1,0,0,4'b0000,2'd2,4'd0));
        add(0,1,0,4'h0,0,0, o(0,0,1,0,0,4'b0000,2'd2,4'd0));
        add(0,1,1,4'h0,0,0, o(0,0,1,0,0,4'b0000,2'd2,4'd0));
        add(0,0,0,4'h0,0,0, o(1,1,0,0,0,4'b0000,2'd0,4'd0));
        // scenario C rows 14..24: hit dst=1, rdy[1] toggling
        add(1,0,0,4'h0,1,1, o(1,0,0,0,0,4'b0010,2'd0,4'd0));
        add(1,0,0,4'h2,1,1, o(1,1,0,1,0,4'b0010,2'd0,4'd0));
        add(0,0,0,4'h0,0,0, o(0,0,0,0,0,4'b0010,2'd1,4'd0));
        add(0,0,0,4'h2,0,0, o(0,0,0,0,0,4'b0010,2'd1,4'd0));
        add(0,0,0,4'h0,0,0, o(0,0,0,0,0,4'b0010,2'd1,4'd1));
        add(0,0,0,4'h2,0,0, o(0,0,0,0,0,4'b0010,2'd1,4'd1));
        add(0,1,0,4'h0,0,0, o(0,0,0,0,0,4'b0010,2'd2,4'd0));
        add(0,1,0,4'h2,0,0, o(0,0,1,0,0,4'b0010,2'd2,4'd0));
        add(0,1,1,4'h0,0,0, o(0,0,0,0,0,4'b0010,2'd2,4'd0));
        add(0,1,1,4'h2,0,0, o(0,0,1,0,1,4'b0010,2'd2,4'd0));
        add(0,0,0,4'h2,0,0, o(1,1,0,0,0,4'b0000,2'd0,4'd0));

        // reset state
        idle();
        rst = 1'b0;
        #2 rst = 1'b1;
        #2;
        chk("rst_outputs", 32'(m_act()), 32'(o(0,0,0,0,0,4'b0000,2'd0,4'd0)));
        chk("rst_pkt_cnt", m_pkt, 32'd0);
        chk("rst_drop_cnt", m_drop, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_rows(0, 6);
        chk("A_pkt_cnt", m_pkt, 32'd1);
        run_rows(7, 13);
        chk("B_drop_cnt", m_drop, 32'd1);
        chk("B_pkt_cnt", m_pkt, 32'd1);
        run_rows(14, 24);
        chk("C_pkt_cnt", m_pkt, 32'd2);

        // zero-metadata instance: HDR then D, then READY
        do_reset();
        hdr_val = 1; cam_hit = 1; dst = 3;
        @(negedge clk);
        chk("Z_hdr", 32'({z_hdr_rdy, z_store, z_val, z_sel}), 32'({1'b1, 1'b1, 4'b1000, 2'd0}));
        @(posedge clk); #1;
        idle(); data_val = 1; data_last = 1;
        @(negedge clk);
        chk("Z_data", 32'({z_data_rdy, z_incr, z_val, z_sel}), 32'({1'b1, 1'b1, 4'b1000, 2'd2}));
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        chk("Z_ready", 32'({z_cam_rd, z_sel, z_pkt}), 32'({1'b1, 2'd0, 8'd1}));

        // illegal channel index on a 3-channel instance is dropped
        do_reset();
        hdr_val = 1; cam_hit = 1; dst = 3;
        @(negedge clk);
        chk("I_hdr", 32'({s_hdr_rdy, s_store, s_val}), 32'({1'b1, 1'b1, 3'b000}));
        @(posedge clk); #1;
        idle(); data_val = 1; data_last = 1;
        @(negedge clk);
        chk("I_drain", 32'({s_data_rdy, s_cam_rd, s_val}), 32'({1'b1, 1'b0, 3'b000}));
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        chk("I_drop_cnt", 32'(s_drop), 32'd1);

        // saturation of the 2-bit counter and clear-then-count
        do_reset();
        drop_pkt(0); drop_pkt(0);
        @(negedge clk);
        chk("S_at_max_m1", 32'(s_drop), 32'd2);
        drop_pkt(0); drop_pkt(0); drop_pkt(0);
        @(negedge clk);
        chk("S_saturated", 32'(s_drop), 32'd3);
        chk("S_main_drop", m_drop, 32'd5);
        drop_pkt(1);
        @(negedge clk);
        chk("S_clr_cnt_sat", 32'(s_drop), 32'd1);
        chk("S_clr_cnt_main", m_drop, 32'd1);
        @(posedge clk); #1;
        clr = 1;
        @(posedge clk); #1;
        clr = 0;
        @(negedge clk);
        chk("S_clr_only", m_drop, 32'd0);

        // reset in the middle of a second hit packet
        do_reset();
        run_rows(0, 6);
        hdr_val = 1; cam_hit = 1; dst = 2;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        data_val = 1; hdr_val = 1; cam_hit = 0;
        @(negedge clk);
        chk("R_in_data", 32'(m_act()), 32'(o(0,0,1,0,0,4'b0100,2'd2,4'd0)));
        #1 rst = 1'b1;
        #1;
        chk("R_outputs", 32'(m_act()), 32'(o(0,0,0,0,0,4'b0000,2'd0,4'd0)));
        chk("R_pkt_cnt", m_pkt, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle();
        @(negedge clk);
        chk("R_ready", 32'(m_act()), 32'(o(1,1,0,0,0,4'b0000,2'd0,4'd0)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
